// File: rtl/axis_pcie_tlp_log_event_mux.sv
// axis_pcie_tlp_log_event_mux
// Merges NUM_CH producer log streams into one valid/ready stream. Each channel
// has its own FIFO, and every entry is timestamped in its write cycle.
// Channels are served round-robin. An AFU SoftReset toggle event has priority
// over all channels. finish_logger starts an orderly drain; flush_done reports
// that the drain is complete.
module axis_pcie_tlp_log_event_mux #(
  parameter int NUM_CH     = 4,
  parameter int MSG_W      = 64,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 64
) (
  input  logic                      clk,
  input  logic                      SoftReset_n,
  input  logic                      afu_softreset,
  input  logic [NUM_CH-1:0]         in_valid,
  input  logic [NUM_CH-1:0]         in_ts_en,
  input  logic [NUM_CH*MSG_W-1:0]   in_msg,
  input  logic                      finish_logger,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(NUM_CH):0]   out_ch,
  output logic                      out_ts_en,
  output logic [TS_W-1:0]           out_ts,
  output logic [MSG_W-1:0]          out_msg,
  output logic [NUM_CH*16-1:0]      drop_cnt,
  output logic                      flush_done
);
  localparam int CH_W  = $clog2(NUM_CH) + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int E_W   = 1 + TS_W + MSG_W;

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_DONE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [TS_W-1:0]       ts_ctr_q, ts_ctr_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                  afu_q, afu_d;
  logic                  rst_pend_q, rst_pend_d;
  logic [1:0]            rst_val_q, rst_val_d;
  logic [PTR_W-1:0]      wr_ptr_q [NUM_CH], wr_ptr_d [NUM_CH];
  logic [PTR_W-1:0]      rd_ptr_q [NUM_CH], rd_ptr_d [NUM_CH];
  logic [15:0]           drop_q [NUM_CH], drop_d [NUM_CH];
  logic [E_W-1:0]        mem_q [NUM_CH][FIFO_DEPTH];
  logic                  out_valid_q, out_valid_d;
  logic [CH_W-1:0]       out_ch_q, out_ch_d;
  logic                  out_ts_en_q, out_ts_en_d;
  logic [TS_W-1:0]       out_ts_q, out_ts_d;
  logic [MSG_W-1:0]      out_msg_q, out_msg_d;
  logic                  flush_done_q, flush_done_d;

  logic [NUM_CH-1:0]     empty_s, full_s, pop_s, wr_en_s;
  logic                  load_s, found_s, all_empty_s;
  logic [CH_W-1:0]       grant_s;
  logic [E_W-1:0]        head_s;

  // FIFO status from wrapping pointer comparison
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      empty_s[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
      full_s[k]  = (wr_ptr_q[k][PTR_W-1] != rd_ptr_q[k][PTR_W-1]) &&
                   (wr_ptr_q[k][AW-1:0] == rd_ptr_q[k][AW-1:0]);
    end
    all_empty_s = &empty_s;
  end

  // Round-robin search from rr_ptr, plus pop/write enables and selected head entry
  always_comb begin
    found_s = 1'b0;
    grant_s = {CH_W{1'b0}};
    head_s  = {E_W{1'b0}};
    load_s  = !out_valid_q || out_ready;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!found_s && !empty_s[k] && (((int'(rr_ptr_q) + i) % NUM_CH) == k)) begin
          found_s = 1'b1;
          grant_s = CH_W'(k);
        end else begin
          found_s = found_s;
        end
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (found_s && (grant_s == CH_W'(k))) begin
        head_s = mem_q[k][rd_ptr_q[k][AW-1:0]];
      end else begin
        head_s = head_s;
      end
      pop_s[k]   = load_s && !rst_pend_q && found_s && (grant_s == CH_W'(k));
      wr_en_s[k] = in_valid[k] && (state_q == ST_RUN) && (!full_s[k] || pop_s[k]);
    end
  end

  // Next-state: counters, FIFO pointers, drop counts, reset-event capture, output stage, FSM
  always_comb begin
    state_d      = state_q;
    ts_ctr_d     = ts_ctr_q + TS_W'(1);
    rr_ptr_d     = rr_ptr_q;
    afu_d        = afu_softreset;
    rst_pend_d   = rst_pend_q;
    rst_val_d    = rst_val_q;
    out_valid_d  = out_valid_q;
    out_ch_d     = out_ch_q;
    out_ts_en_d  = out_ts_en_q;
    out_ts_d     = out_ts_q;
    out_msg_d    = out_msg_q;
    for (int k = 0; k < NUM_CH; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k] + (wr_en_s[k] ? PTR_W'(1) : PTR_W'(0));
      rd_ptr_d[k] = rd_ptr_q[k] + (pop_s[k] ? PTR_W'(1) : PTR_W'(0));
      if (in_valid[k] && (state_q == ST_RUN) && full_s[k] && !pop_s[k] && (drop_q[k] != 16'hFFFF)) begin
        drop_d[k] = drop_q[k] + 16'd1;
      end else begin
        drop_d[k] = drop_q[k];
      end
    end
    // Output register: reset event first, then the round-robin grant
    if (load_s) begin
      if (rst_pend_q) begin
        out_valid_d = 1'b1;
        out_ch_d    = CH_W'(NUM_CH);
        out_ts_en_d = 1'b1;
        out_ts_d    = ts_ctr_q;
        out_msg_d   = MSG_W'(rst_val_q);
        rst_pend_d  = 1'b0;
      end else if (found_s) begin
        out_valid_d = 1'b1;
        out_ch_d    = grant_s;
        out_ts_en_d = head_s[E_W-1];
        out_ts_d    = head_s[MSG_W +: TS_W];
        out_msg_d   = head_s[MSG_W-1:0];
        rr_ptr_d    = (grant_s == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : grant_s + CH_W'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
    // A toggle captured this cycle wins over the clear above; repeat toggles coalesce
    if ((state_q != ST_DONE) && (afu_softreset != afu_q)) begin
      rst_pend_d = 1'b1;
      rst_val_d  = {afu_q, afu_softreset};
    end else begin
      rst_val_d  = rst_val_q;
    end
    case (state_q)
      ST_RUN: begin
        if (finish_logger) state_d = ST_DRAIN;
        else               state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (all_empty_s && !rst_pend_q && !out_valid_q) state_d = ST_DONE;
        else                                             state_d = ST_DRAIN;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
    flush_done_d = (state_d == ST_DONE);
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      state_q      <= ST_RUN;
      ts_ctr_q     <= {TS_W{1'b0}};
      rr_ptr_q     <= {CH_W{1'b0}};
      afu_q        <= 1'b0;
      rst_pend_q   <= 1'b0;
      rst_val_q    <= 2'b00;
      out_valid_q  <= 1'b0;
      out_ch_q     <= {CH_W{1'b0}};
      out_ts_en_q  <= 1'b0;
      out_ts_q     <= {TS_W{1'b0}};
      out_msg_q    <= {MSG_W{1'b0}};
      flush_done_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr_q[k] <= {PTR_W{1'b0}};
        rd_ptr_q[k] <= {PTR_W{1'b0}};
        drop_q[k]   <= 16'd0;
      end
    end else begin
      state_q      <= state_d;
      ts_ctr_q     <= ts_ctr_d;
      rr_ptr_q     <= rr_ptr_d;
      afu_q        <= afu_d;
      rst_pend_q   <= rst_pend_d;
      rst_val_q    <= rst_val_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_ts_en_q  <= out_ts_en_d;
      out_ts_q     <= out_ts_d;
      out_msg_q    <= out_msg_d;
      flush_done_q <= flush_done_d;
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
        drop_q[k]   <= drop_d[k];
      end
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr_en_s[k]) begin
        mem_q[k][wr_ptr_q[k][AW-1:0]] <= {in_ts_en[k], ts_ctr_q, in_msg[k*MSG_W +: MSG_W]};
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_ts_en  = out_ts_en_q;
  assign out_ts     = out_ts_q;
  assign out_msg    = out_msg_q;
  assign flush_done = flush_done_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_drop
    assign drop_cnt[g*16 +: 16] = drop_q[g];
  end
endmodule

// File: tb/tb_axis_pcie_tlp_log_event_mux.sv
// Directed testbench for axis_pcie_tlp_log_event_mux (default parameters).
module tb_axis_pcie_tlp_log_event_mux;
  localparam int NUM_CH = 4;
  localparam int MSG_W  = 64;
  localparam int TS_W   = 64;

  logic                    clk;
  logic                    SoftReset_n;
  logic                    afu_softreset;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ts_en;
  logic [NUM_CH*MSG_W-1:0] in_msg;
  logic                    finish_logger;
  logic                    out_valid;
  logic                    out_ready;
  logic [2:0]              out_ch;
  logic                    out_ts_en;
  logic [TS_W-1:0]         out_ts;
  logic [MSG_W-1:0]        out_msg;
  logic [NUM_CH*16-1:0]    drop_cnt;
  logic                    flush_done;

  int          vectors;
  int          miscompares;
  logic [63:0] tb_ts;
  logic [63:0] exp_ts;

  axis_pcie_tlp_log_event_mux dut (
    .clk(clk), .SoftReset_n(SoftReset_n), .afu_softreset(afu_softreset),
    .in_valid(in_valid), .in_ts_en(in_ts_en), .in_msg(in_msg),
    .finish_logger(finish_logger), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_ts_en(out_ts_en), .out_ts(out_ts), .out_msg(out_msg),
    .drop_cnt(drop_cnt), .flush_done(flush_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference free-running timestamp: cycles since reset release
  always @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) tb_ts <= 64'd0;
    else              tb_ts <= tb_ts + 64'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input int ch, input logic [63:0] msg);
    in_valid[ch] = 1'b1;
    in_msg[ch*MSG_W +: MSG_W] = msg;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    SoftReset_n = 1'b0; afu_softreset = 1'b0; in_valid = '0; in_ts_en = '0;
    in_msg = '0; finish_logger = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ch", 64'(out_ch), 64'd0);
    chk("rst_ts", out_ts, 64'd0);
    chk("rst_msg", out_msg, 64'd0);
    chk("rst_drop", drop_cnt, 64'd0);
    chk("rst_flush", 64'(flush_done), 64'd0);
    SoftReset_n = 1'b1;

    // 1: single event, timestamp 10, two-cycle latency
    for (int n = 0; n < 50 && tb_ts != 64'd10; n++) step();
    drive(0, 64'hA5); in_ts_en[0] = 1'b1;
    step();
    in_valid = '0; in_ts_en = '0;
    chk("t1_not_yet", 64'(out_valid), 64'd0);
    step();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_ch", 64'(out_ch), 64'd0);
    chk("t1_ts", out_ts, 64'd10);
    chk("t1_msg", out_msg, 64'hA5);
    chk("t1_ts_en", 64'(out_ts_en), 64'd1);
    step();
    chk("t1_drained", 64'(out_valid), 64'd0);

    // Fresh start so the round-robin pointer is at channel 0
    SoftReset_n = 1'b0;
    step();
    SoftReset_n = 1'b1;

    // 2: all channels at once -> 0,1,2,3 back-to-back
    for (int k = 0; k < NUM_CH; k++) drive(k, 64'h10 + 64'(k));
    step();
    in_valid = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      step();
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_ch", 64'(out_ch), 64'(k));
      chk("t2_msg", out_msg, 64'h10 + 64'(k));
    end
    drive(0, 64'h20); drive(2, 64'h22);
    step(); in_valid = '0;
    step(); chk("t2_wrap_first", 64'(out_ch), 64'd0);
    step(); chk("t2_wrap_second", 64'(out_ch), 64'd2);
    drive(0, 64'h30); drive(3, 64'h33);
    step(); in_valid = '0;
    step(); chk("t2_rr_from3", 64'(out_ch), 64'd3);
    step(); chk("t2_rr_wrap0", 64'(out_ch), 64'd0);
    step(); chk("t2_idle", 64'(out_valid), 64'd0);

    // 3 + 5: output held by a ch0 event, 10 events on ch1 -> 8 queued, 2 dropped
    out_ready = 1'b0;
    drive(0, 64'hC0);
    step(); in_valid = '0;
    step();
    chk("t3_hold_valid", 64'(out_valid), 64'd1);
    chk("t3_hold_msg", out_msg, 64'hC0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 64'h100 + 64'(i));
      step();
      if (i < 5) begin
        chk("t5_stall_valid", 64'(out_valid), 64'd1);
        chk("t5_stall_ch", 64'(out_ch), 64'd0);
        chk("t5_stall_msg", out_msg, 64'hC0);
      end
    end
    in_valid = '0;
    chk("t3_drop_cnt", drop_cnt, 64'h0000_0000_0002_0000);
    chk("t5_still_held", out_msg, 64'hC0);
    out_ready = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("t3_order_ch", 64'(out_ch), 64'd1);
      chk("t3_order_msg", out_msg, 64'h100 + 64'(i));
      step();
    end
    chk("t3_idle", 64'(out_valid), 64'd0);

    // 4: SoftReset toggle together with a ch2 event -> reset event first
    drive(2, 64'h22); afu_softreset = 1'b1;
    step(); in_valid = '0;
    exp_ts = tb_ts;
    step();
    chk("t4_rst_ch", 64'(out_ch), 64'd4);
    chk("t4_rst_msg", out_msg, 64'h1);
    chk("t4_rst_ts", out_ts, exp_ts);
    chk("t4_rst_ts_en", 64'(out_ts_en), 64'd1);
    step();
    chk("t4_ch2_ch", 64'(out_ch), 64'd2);
    chk("t4_ch2_msg", out_msg, 64'h22);
    step();
    chk("t4_idle", 64'(out_valid), 64'd0);

    // 6: finish with three events queued; later inputs ignored
    out_ready = 1'b0;
    drive(1, 64'h61); drive(2, 64'h62); drive(3, 64'h63);
    step(); in_valid = '0; finish_logger = 1'b1;
    step(); finish_logger = 1'b0;
    chk("t6_first", 64'(out_ch), 64'd3);
    in_valid = 4'hF;
    repeat (3) step();
    in_valid = '0;
    chk("t6_no_drop", drop_cnt, 64'h0000_0000_0002_0000);
    chk("t6_not_done", 64'(flush_done), 64'd0);
    out_ready = 1'b1;
    chk("t6_msg3", out_msg, 64'h63);
    step(); chk("t6_ch1", 64'(out_ch), 64'd1); chk("t6_msg1", out_msg, 64'h61);
    step(); chk("t6_ch2", 64'(out_ch), 64'd2); chk("t6_msg2", out_msg, 64'h62);
    step(); chk("t6_empty", 64'(out_valid), 64'd0);
    for (int n = 0; n < 10 && !flush_done; n++) step();
    chk("t6_flush_done", 64'(flush_done), 64'd1);
    afu_softreset = 1'b0;
    repeat (3) step();
    chk("t6_done_no_rst_evt", 64'(out_valid), 64'd0);
    chk("t6_done_sticky", 64'(flush_done), 64'd1);

    // Asynchronous reset mid-cycle clears everything
    SoftReset_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_ch", 64'(out_ch), 64'd0);
    chk("t6_rst_ts", out_ts, 64'd0);
    chk("t6_rst_msg", out_msg, 64'd0);
    chk("t6_rst_ts_en", 64'(out_ts_en), 64'd0);
    chk("t6_rst_drop", drop_cnt, 64'd0);
    chk("t6_rst_flush", 64'(flush_done), 64'd0);
    step();
    SoftReset_n = 1'b1;
    drive(1, 64'h77);
    step(); in_valid = '0;
    step();
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_ch", 64'(out_ch), 64'd1);
    chk("post_rst_msg", out_msg, 64'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
